// File: rtl/ddr3_dfi_phy_sched.sv
// DFI-to-PHY scheduler for a DDR3 PHY: write/read latency delay lines, DQS
// enable shaping, per-lane read slip alignment and runtime latency configuration.
module ddr3_dfi_phy_sched #(
  parameter int DDR3_WIDTH     = 16,
  parameter int DDR3_MASKS     = DDR3_WIDTH / 8,
  parameter int MAX_RW_LATENCY = 16,
  parameter int TPHY_RDLAT     = 4,
  parameter int TPHY_WRLAT     = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cfg_valid_i,
  input  logic [31:0]               cfg_i,
  output logic                      cfg_ready_o,
  input  logic                      dfi_wrdata_en_i,
  input  logic [2*DDR3_WIDTH-1:0]   dfi_wrdata_i,
  input  logic [2*DDR3_MASKS-1:0]   dfi_wrdata_mask_i,
  input  logic                      dfi_rddata_en_i,
  output logic [2*DDR3_WIDTH-1:0]   dfi_rddata_o,
  output logic                      dfi_rddata_valid_o,
  output logic [1:0]                dfi_rddata_dnv_o,
  output logic [2*DDR3_WIDTH-1:0]   phy_wrdata_o,
  output logic [2*DDR3_MASKS-1:0]   phy_wrmask_o,
  output logic                      phy_dq_oe_o,
  output logic                      phy_dqs_oe_o,
  input  logic [2*DDR3_WIDTH-1:0]   phy_rddata_i,
  output logic                      err_o
);

  localparam int DW    = 2 * DDR3_WIDTH;
  localparam int MW    = 2 * DDR3_MASKS;
  localparam int SR    = MAX_RW_LATENCY;
  localparam int LAT_W = $clog2(MAX_RW_LATENCY + 1);

  logic [LAT_W-1:0]          wr_lat;
  logic [LAT_W-1:0]          rd_lat;
  logic [DDR3_MASKS-1:0]     lane_slip;
  logic [SR-1:0]             wr_sr;
  logic [SR-1:0]             rd_sr;
  logic [SR:0]               wr_ext;
  logic [SR:0]               rd_ext;
  logic [SR-1:0][DW-1:0]     wr_data_sr;
  logic [SR-1:0][MW-1:0]     wr_mask_sr;
  logic [SR:0][DW-1:0]       wr_data_ext;
  logic [SR:0][MW-1:0]       wr_mask_ext;
  logic [DW-1:0]             rd_data_p1;
  logic [DW-1:0]             rd_data_p2;
  logic [DW-1:0]             rd_aligned;
  logic [DW-1:0]             rd_hold;
  logic                      err;
  logic                      ready;
  logic                      dq_oe;
  logic                      dqs_oe;
  logic                      rd_vld;
  logic                      unused_cfg;

  function automatic logic [LAT_W-1:0] clamp_lat(input logic [3:0] v, input int hi);
    int x;
    x = int'(v);
    if (x < 1) x = 1;
    else if (x > hi) x = hi;
    return LAT_W'(x);
  endfunction

  // Index j of each *_ext vector is the value seen j cycles ago (j=0: this cycle).
  assign wr_ext      = {wr_sr, dfi_wrdata_en_i};
  assign rd_ext      = {rd_sr, dfi_rddata_en_i};
  assign wr_data_ext = {wr_data_sr, dfi_wrdata_i};
  assign wr_mask_ext = {wr_mask_sr, dfi_wrdata_mask_i};

  assign ready  = ~|wr_sr & ~|rd_sr & ~dfi_wrdata_en_i & ~dfi_rddata_en_i;
  assign dq_oe  = wr_ext[wr_lat] & ~reset;
  assign dqs_oe = (wr_ext[wr_lat - LAT_W'(1)] | wr_ext[wr_lat] | wr_ext[wr_lat + LAT_W'(1)]) & ~reset;
  assign rd_vld = rd_ext[rd_lat + LAT_W'(2)] & ~reset;

  // Slipped lanes were sampled one cycle later, so they skip the second register.
  for (genvar b = 0; b < MW; b++) begin : g_lane
    assign rd_aligned[8*b +: 8] = lane_slip[b % DDR3_MASKS] ? rd_data_p1[8*b +: 8]
                                                            : rd_data_p2[8*b +: 8];
  end

  assign cfg_ready_o        = reset | ready;
  assign phy_dq_oe_o        = dq_oe;
  assign phy_dqs_oe_o       = dqs_oe;
  assign phy_wrdata_o       = dq_oe ? wr_data_ext[wr_lat] : '0;
  assign phy_wrmask_o       = dq_oe ? wr_mask_ext[wr_lat] : '1;
  assign dfi_rddata_valid_o = rd_vld;
  assign dfi_rddata_o       = reset ? '0 : (rd_vld ? rd_aligned : rd_hold);
  assign dfi_rddata_dnv_o   = 2'b00;
  assign err_o              = err & ~reset;
  assign unused_cfg         = ^{cfg_i[31:16+DDR3_MASKS], cfg_i[15:12], cfg_i[7:4]};

  // Control stage: latency config, enable delay lines, error flag, read hold
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_lat    <= LAT_W'(TPHY_WRLAT);
      rd_lat    <= LAT_W'(TPHY_RDLAT);
      lane_slip <= '0;
      wr_sr     <= '0;
      rd_sr     <= '0;
      err       <= 1'b0;
      rd_hold   <= '0;
    end else begin
      wr_sr <= {wr_sr[SR-2:0], dfi_wrdata_en_i};
      rd_sr <= {rd_sr[SR-2:0], dfi_rddata_en_i};
      if (cfg_valid_i && ready) begin
        wr_lat    <= clamp_lat(cfg_i[3:0], MAX_RW_LATENCY - 2);
        rd_lat    <= clamp_lat(cfg_i[11:8], MAX_RW_LATENCY - 3);
        lane_slip <= cfg_i[16 +: DDR3_MASKS];
      end
      if ((cfg_valid_i && !ready) ||
          (dfi_rddata_en_i && |wr_sr) ||
          (dfi_wrdata_en_i && |rd_sr))
        err <= 1'b1;
      if (rd_vld)
        rd_hold <= rd_aligned;
    end
  end

  // Data stage: write beat delay line and two-deep read capture pipeline
  always_ff @(posedge clock) begin
    wr_data_sr <= {wr_data_sr[SR-2:0], dfi_wrdata_i};
    wr_mask_sr <= {wr_mask_sr[SR-2:0], dfi_wrdata_mask_i};
    rd_data_p1 <= phy_rddata_i;
    rd_data_p2 <= rd_data_p1;
  end

endmodule

// File: tb/tb_ddr3_dfi_phy_sched.sv
// Directed bench for ddr3_dfi_phy_sched with write/read scoreboards checked by
// a negedge monitor and per-cycle enable checks in the stimulus sequence.
module tb_ddr3_dfi_phy_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [31:0] cfg = '0;
  logic        cfg_ready;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_mask = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  dnv;
  logic [31:0] phy_wrdata;
  logic [3:0]  phy_wrmask;
  logic        dq_oe;
  logic        dqs_oe;
  logic [31:0] phy_rddata = '0;
  logic        err;

  ddr3_dfi_phy_sched dut (
    .clock(clock), .reset(reset),
    .cfg_valid_i(cfg_valid), .cfg_i(cfg), .cfg_ready_o(cfg_ready),
    .dfi_wrdata_en_i(wr_en), .dfi_wrdata_i(wr_data), .dfi_wrdata_mask_i(wr_mask),
    .dfi_rddata_en_i(rd_en), .dfi_rddata_o(rd_data), .dfi_rddata_valid_o(rd_valid),
    .dfi_rddata_dnv_o(dnv), .phy_wrdata_o(phy_wrdata), .phy_wrmask_o(phy_wrmask),
    .phy_dq_oe_o(dq_oe), .phy_dqs_oe_o(dqs_oe), .phy_rddata_i(phy_rddata), .err_o(err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int cyc; logic [31:0] data; logic [3:0] mask; } wexp_t;
  typedef struct { int cyc; logic [31:0] data; } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  int          checks = 0;
  int          errors = 0;
  int          m_wl = 3;
  int          m_rl = 4;
  logic [1:0]  m_slip = 2'b00;
  int          wcount = 0;
  logic [31:0] last_rd = '0;
  bit          mon_on = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pat(input int c);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = 8'(c * 7 + b * 61 + 3);
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input int t, input int rl, input logic [1:0] slip);
    logic [31:0] r, p;
    for (int b = 0; b < 4; b++) begin
      p = pat(t + rl + int'(slip[b % 2]));
      r[8*b +: 8] = p[8*b +: 8];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    phy_rddata = pat(cyc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dq_oe"}, 32'(dq_oe), 32'd0);
    chk({tag, "_dqs_oe"}, 32'(dqs_oe), 32'd0);
    chk({tag, "_wrdata"}, phy_wrdata, 32'd0);
    chk({tag, "_wrmask"}, 32'(phy_wrmask), 32'hF);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
  endtask

  // Scoreboard monitor: every beat leaving the DUT is matched against the queues.
  always @(negedge clock) begin
    if (mon_on) begin
      wexp_t w;
      rexp_t r;
      chk("dnv", 32'(dnv), 32'd0);
      if (reset) last_rd = '0;
      if (dq_oe) begin
        if (wq.size() == 0) chk("wr_unexpected_oe", 32'(dq_oe), 32'd0);
        else begin
          w = wq.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
          chk("wr_data", phy_wrdata, w.data);
          chk("wr_mask", 32'(phy_wrmask), 32'(w.mask));
        end
      end else begin
        chk("wr_idle_data", phy_wrdata, 32'd0);
        chk("wr_idle_mask", 32'(phy_wrmask), 32'hF);
      end
      if (rd_valid) begin
        if (rq.size() == 0) chk("rd_unexpected_valid", 32'(rd_valid), 32'd0);
        else begin
          r = rq.pop_front();
          chk("rd_cycle", 32'(cyc), 32'(r.cyc));
          chk("rd_data", rd_data, r.data);
          last_rd = r.data;
        end
      end else begin
        chk("rd_hold", rd_data, last_rd);
      end
    end
  end

  task automatic run_traffic(input logic [63:0] wb, input logic [63:0] rb, input int n);
    logic e_dq, e_dqs, e_vld;
    for (int rel = 0; rel < n; rel++) begin
      tick();
      wr_en = wb[rel];
      rd_en = rb[rel];
      if (wb[rel]) begin
        wr_data = 32'h1111_1111 * 32'((wcount % 15) + 1);
        wr_mask = 4'(wcount * 5);
        wq.push_back('{cyc + m_wl, wr_data, wr_mask});
        wcount++;
      end else begin
        wr_data = $urandom;
        wr_mask = 4'($urandom);
      end
      if (rb[rel]) rq.push_back('{cyc + m_rl + 2, exp_rd(cyc, m_rl, m_slip)});
      @(negedge clock);
      e_dq  = (rel >= m_wl) && wb[rel - m_wl];
      e_vld = (rel >= m_rl + 2) && rb[rel - m_rl - 2];
      e_dqs = 1'b0;
      for (int d = m_wl - 1; d <= m_wl + 1; d++)
        if (rel - d >= 0 && wb[rel - d]) e_dqs = 1'b1;
      chk("dq_oe", 32'(dq_oe), 32'(e_dq));
      chk("dqs_oe", 32'(dqs_oe), 32'(e_dqs));
      chk("rd_valid", 32'(rd_valid), 32'(e_vld));
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic do_cfg(input logic [31:0] word, input int wl, input int rl, input logic [1:0] slip);
    tick();
    cfg_valid = 1'b1;
    cfg = word;
    @(negedge clock);
    chk("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    m_wl = wl;
    m_rl = rl;
    m_slip = slip;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    @(negedge clock);
    chk_reset_vals("in_reset");
    mon_on = 1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("after_reset");

    // Default write burst, then the two gap cases
    run_traffic(64'h3C00, 64'h0, 32);
    run_traffic(64'h2400, 64'h0, 32);
    run_traffic(64'h4400, 64'h0, 32);
    chk("err_clean", 32'(err), 32'd0);

    // wr_lat=0 clamps to 1; wr_lat=15/rd_lat=15 clamp to 14/13
    do_cfg(32'h0000_0400, 1, 4, 2'b00);
    run_traffic(64'h260, 64'h0, 32);
    do_cfg(32'h0000_0F0F, 14, 13, 2'b00);
    run_traffic(64'h4, 64'h0, 24);
    run_traffic(64'h0, 64'h4, 24);

    // Read with lane 1 slipped
    do_cfg(32'h0002_0603, 3, 6, 2'b10);
    run_traffic(64'h0, 64'h0190_0000, 44);
    chk("err_after_reads", 32'(err), 32'd0);

    // Config attempt while a read is in flight is ignored and flags an error
    for (int rel = 0; rel < 20; rel++) begin
      tick();
      rd_en = (rel == 2);
      cfg_valid = (rel == 4);
      cfg = 32'h0000_0305;
      if (rel == 2) rq.push_back('{cyc + 8, exp_rd(cyc, 6, 2'b10)});
      @(negedge clock);
      if (rel == 4) chk("cfg_ready_busy", 32'(cfg_ready), 32'd0);
      chk("rd_valid_busy", 32'(rd_valid), 32'(rel == 10));
      chk("err_busy_cfg", 32'(err), 32'(rel >= 5));
    end
    rd_en = 1'b0;
    cfg_valid = 1'b0;

    // Reset in the middle of a write burst
    for (int rel = 0; rel < 20; rel++) begin
      tick();
      reset = (rel == 12);
      wr_en = (rel == 10 || rel == 11);
      wr_data = $urandom;
      @(negedge clock);
      chk("dq_oe_midreset", 32'(dq_oe), 32'd0);
      if (rel == 12) chk_reset_vals("mid_reset");
      if (rel == 13) chk_reset_vals("post_mid_reset");
      if (rel < 12) chk("err_before_reset", 32'(err), 32'd1);
      if (rel > 12) chk("dqs_after_reset", 32'(dqs_oe), 32'd0);
    end
    wr_en = 1'b0;
    reset = 1'b0;
    m_wl = 3;
    m_rl = 4;
    m_slip = 2'b00;
    wcount = 0;
    run_traffic(64'h3C00, 64'h0, 32);
    chk("err_after_reburst", 32'(err), 32'd0);

    // Read while writes are in flight, then write while reads are in flight
    run_traffic(64'h4, 64'h8, 24);
    chk("err_rd_over_wr", 32'(err), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    chk("err_cleared", 32'(err), 32'd0);
    run_traffic(64'h8, 64'h4, 24);
    chk("err_wr_over_rd", 32'(err), 32'd1);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_dfi_phy_sched.md
DDR3_DFI_PHY_SCHED -- requirements
Module: ddr3_dfi_phy_sched

Interface
REQ-001 Parameter DDR3_WIDTH, default 16: DQ width per DDR edge.
REQ-002 Parameter DDR3_MASKS, default DDR3_WIDTH/8: byte-lane count; DFI data is 2*DDR3_WIDTH wide and DFI mask is 2*DDR3_MASKS wide.
REQ-003 Parameter MAX_RW_LATENCY, default 16: depth of the latency shift registers.
REQ-004 Parameter TPHY_RDLAT, default 4: reset value of rd_lat.
REQ-005 Parameter TPHY_WRLAT, default 3: reset value of wr_lat.
REQ-006 clock  in  1  single bus clock; every register is clocked on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 cfg_valid_i  in  1  config write strobe.
REQ-009 cfg_i  in  32  config word: [3:0] wr_lat, [11:8] rd_lat, [16+DDR3_MASKS-1:16] lane_slip.
REQ-010 cfg_ready_o  out  1  high when a config write will be accepted.
REQ-011 dfi_wrdata_en_i, dfi_wrdata_i, dfi_wrdata_mask_i  in  1, 2*DDR3_WIDTH, 2*DDR3_MASKS  DFI write beat.
REQ-012 dfi_rddata_en_i  in  1  DFI read request for one beat.
REQ-013 dfi_rddata_o, dfi_rddata_valid_o, dfi_rddata_dnv_o  out  2*DDR3_WIDTH, 1, 2  DFI read return.
REQ-014 phy_wrdata_o, phy_wrmask_o  out  2*DDR3_WIDTH, 2*DDR3_MASKS  beat to the serialisers.
REQ-015 phy_dq_oe_o, phy_dqs_oe_o  out  1, 1  active-high output enables.
REQ-016 phy_rddata_i  in  2*DDR3_WIDTH  deserialised read beat; lane k occupies bytes k and k+DDR3_MASKS.
REQ-017 err_o  out  1  sticky error flag.

Function
REQ-018 wr_lat, rd_lat and lane_slip registers: loaded only when cfg_valid_i and cfg_ready_o are both high; the new value takes effect on the next cycle.
REQ-019 Clamping: wr_lat is clamped to 1..MAX_RW_LATENCY-2 and rd_lat to 1..MAX_RW_LATENCY-3; the clamp is applied when the config write is loaded.
REQ-020 cfg_ready_o: high only when all write/read shift registers are zero and both dfi_*_en_i inputs are low.
REQ-021 cfg_valid_i while cfg_ready_o is low: the write is ignored and err_o is set.
REQ-022 Write delay line: a write enable at cycle t asserts phy_dq_oe_o at cycle t+wr_lat for exactly one cycle per enabled beat.
REQ-023 Write data: phy_wrdata_o/phy_wrmask_o at cycle t+wr_lat equal the dfi_wrdata_i/mask sampled at t.
REQ-024 Idle write outputs: while phy_dq_oe_o is low, phy_wrdata_o is 0 and phy_wrmask_o is all ones.
REQ-025 DQS preamble/postamble: phy_dqs_oe_o is high from cycle t+wr_lat-1 through cycle (last beat)+wr_lat+1.
REQ-026 Back-to-back writes: bursts separated by ≤2 idle enable cycles keep phy_dqs_oe_o continuously high; 3 or more idle cycles give at least one low cycle.
REQ-027 Read valid: a read enable at cycle t gives dfi_rddata_valid_o high at cycle t+rd_lat+2 for one cycle; contiguous enables give contiguous valids.
REQ-028 Lane alignment: lane k with lane_slip[k]=0 samples phy_rddata_i at t+rd_lat and passes through two registers; with lane_slip[k]=1 it samples at t+rd_lat+1 and passes through one register.
REQ-029 Read data output: all lanes appear aligned on dfi_rddata_o at the valid cycle; dfi_rddata_o is held from the last valid beat when valid is low.
REQ-030 dfi_rddata_dnv_o is constant 2'b00.
REQ-031 Write/read overlap: dfi_rddata_en_i asserted while any write shift-register bit is set sets err_o; the read is still scheduled.
REQ-032 Read/write overlap: dfi_wrdata_en_i asserted while any read shift-register bit is set also sets err_o; the write is still scheduled.
REQ-033 err_o is cleared only by reset.

Reset
REQ-034 On reset: wr_lat=TPHY_WRLAT, rd_lat=TPHY_RDLAT, lane_slip=0 and all shift registers cleared; in-flight bursts are discarded with no partial beats emitted.
REQ-035 Output values during and one cycle after reset: phy_dq_oe_o=0, phy_dqs_oe_o=0, phy_wrdata_o=0, phy_wrmask_o=all ones, dfi_rddata_valid_o=0, dfi_rddata_o=0, err_o=0, cfg_ready_o=1.

Verification
REQ-036 Default write: 4 contiguous beats with data 0x11111111..0x44444444 at t=10 -> dq_oe high at cycles 13-16 with the same data in order; dqs_oe high at cycles 12-17.
REQ-037 Write gap: beats at t=10 and t=13 -> dqs_oe stays high at 12-17; beats at t=10 and t=14 -> dqs_oe is low at cycle 15 only.
REQ-038 Read with slip: cfg rd_lat=6, lane_slip=2'b10; drive lane0 at t+6 and lane1 at t+7 for a read at t=20 -> valid at 28 with both lanes correct.
REQ-039 Config while busy: a read is in flight and a cfg write arrives -> cfg_ready_o=0, the config is unchanged and err_o=1; a cfg_i with wr_lat=0 loads wr_lat=1.
REQ-040 Reset mid-operation: reset at cycle 12 of the REQ-036 burst -> no dq_oe afterwards, all outputs at reset values, and a new burst at default latency behaves per REQ-036.
